// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, request source and
// the memory request bundle.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/arb_grant_sel.sv
// Picks which requester gets the memory port next.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise D always beats I.
module arb_grant_sel
    import mem_arb_pkg::*;
(
    input  logic     i_valid,
    input  logic     d_valid,
`ifdef MEM_ARB_RR_EN
    input  arb_src_t last_grant,
`endif
    output logic     any_valid,
    output arb_src_t next_src
);

    always_comb begin
        any_valid = i_valid | d_valid;
`ifdef MEM_ARB_RR_EN
        if (i_valid && d_valid) begin
            next_src = (last_grant == SRC_I) ? SRC_D : SRC_I;
        end else begin
            next_src = d_valid ? SRC_D : SRC_I;
        end
`else
        next_src = d_valid ? SRC_D : SRC_I;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D),
// one transaction at a time. MEM_ARB_RR_EN enables round-robin arbitration.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and register the grant
// I_ADDR | fetch address phase, m_valid high until m_addr_ok
// I_DATA | fetch waiting for m_data_ok
// D_ADDR | load/store address phase, m_valid high until m_addr_ok
// D_DATA | load/store waiting for m_data_ok
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    // Widths must match the mem_arb_pkg request bundle.
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                i_valid,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ok,
    input  logic                d_valid,
    input  logic                d_write,
    input  logic [DATA_W/8-1:0] d_strobe,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ok,
    output logic                m_valid,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_strobe,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_addr_ok,
    input  logic                m_data_ok,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_t state, state_nxt;
    arb_src_t   src_q, next_src;
    logic       any_valid;
    logic       done;
    logic       is_addr;
    mem_req_t   req;

`ifdef MEM_ARB_RR_EN
    arb_src_t   last_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= SRC_I;
        end else if (state == IDLE && any_valid) begin
            last_grant <= next_src;
        end
    end
`endif

    arb_grant_sel u_grant_sel (
        .i_valid    (i_valid),
        .d_valid    (d_valid),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .any_valid  (any_valid),
        .next_src   (next_src)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            src_q <= SRC_I;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_valid) begin
                src_q <= next_src;
            end
        end
    end

    // A data_ok together with addr_ok finishes the transaction without a data phase.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_nxt = (next_src == SRC_D) ? D_ADDR : I_ADDR;
                end
            end
            I_ADDR, D_ADDR: begin
                if (m_addr_ok) begin
                    if (m_data_ok) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = (state == I_ADDR) ? I_DATA : D_DATA;
                    end
                end
            end
            I_DATA, D_DATA: begin
                if (m_data_ok) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_ok    = done && (src_q == SRC_I);
        d_ok    = done && (src_q == SRC_D);
        i_rdata = i_ok ? m_rdata : '0;
        d_rdata = d_ok ? m_rdata : '0;
    end

    assign is_addr = (state == I_ADDR) || (state == D_ADDR);

    // Fetches and loads never carry strobes or write data onto the bus.
    always_comb begin
        req = '0;
        if (is_addr) begin
            req.valid = 1'b1;
            if (src_q == SRC_D) begin
                req.write  = d_write;
                req.strobe = d_write ? d_strobe : '0;
                req.addr   = d_addr;
                req.wdata  = d_write ? d_wdata : '0;
            end else begin
                req.addr   = i_addr;
            end
        end
    end

    assign m_valid  = req.valid;
    assign m_write  = req.write;
    assign m_strobe = req.strobe;
    assign m_addr   = req.addr;
    assign m_wdata  = req.wdata;

    a_no_stray_data_ok: assert property (@(posedge clk) disable iff (!resetn)
        m_data_ok |-> ((state == I_DATA) || (state == D_DATA) || (is_addr && m_addr_ok)));

    a_i_held: assert property (@(posedge clk) disable iff (!resetn)
        ((state == I_ADDR) || (state == I_DATA)) |-> i_valid);

    a_d_held: assert property (@(posedge clk) disable iff (!resetn)
        ((state == D_ADDR) || (state == D_DATA)) |-> d_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences for reset
// and contention, and randomized traffic checked by a transaction-level model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_valid, d_valid, d_write;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_strobe;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ok, d_ok;
    logic        m_valid, m_write;
    logic [3:0]  m_strobe;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_addr_ok, m_data_ok;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ok      (i_ok),
        .d_valid   (d_valid),
        .d_write   (d_write),
        .d_strobe  (d_strobe),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ok      (d_ok),
        .m_valid   (m_valid),
        .m_write   (m_write),
        .m_strobe  (m_strobe),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok),
        .m_rdata   (m_rdata)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_zero();
        i_valid = 1'b0; i_addr = '0;
        d_valid = 1'b0; d_write = 1'b0; d_strobe = '0; d_addr = '0; d_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    endtask

    // ---------------- transaction-level model state ----------------
    typedef struct {
        logic        write;
        logic [3:0]  strobe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic [31:0] iq[$];
    dreq_t       dq[$];
    bit          log_q[$];       // completion order, 1 = D
    bit          i_pres, d_pres;
    int          i_hold, d_hold;
    bit          outst, addr_ph, cur;
`ifdef MEM_ARB_RR_EN
    bit          last_src;
`endif
    bit          mem_dph;
    int          mem_lat;
    logic [31:0] mem_rd;
    int          iok_cnt, dok_cnt;

    task automatic model_reset();
        outst = 0; addr_ph = 0; cur = 0; mem_dph = 0; mem_lat = 0;
        i_pres = 0; d_pres = 0; i_hold = 0; d_hold = 0;
`ifdef MEM_ARB_RR_EN
        last_src = 0;
`endif
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        i_valid = 1'b1; i_addr = 32'h1111_1110;
        d_valid = 1'b1; d_write = 1'b1; d_strobe = 4'hF; d_addr = 32'h2222_2220; d_wdata = 32'hFFFF_FFFF;
        m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'hA5A5_A5A5;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_m_valid", m_valid, 0);
            check("rst_i_ok", i_ok, 0);
            check("rst_d_ok", d_ok, 0);
            check("rst_m_addr", m_addr, 0);
        end
        drive_zero();
        resetn = 1'b1;
        model_reset();
    endtask

    // Requesters hold each queued request until its completion; the memory
    // accepts/finishes with the given probabilities. Every cycle is compared
    // against the arbitration rules.
    task automatic run_traffic(input int budget, input int gap_max, input int acc_pct,
                               input int same_pct, input int lat_max);
        int          cyc;
        bit          done, e_iok, e_dok, w;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_strb;
        cyc = 0;
        while ((iq.size() != 0 || dq.size() != 0 || outst) && cyc < budget) begin
            @(posedge clk); #1;
            if (!i_pres && iq.size() != 0) begin
                if (i_hold == 0) i_pres = 1; else i_hold--;
            end
            if (!d_pres && dq.size() != 0) begin
                if (d_hold == 0) d_pres = 1; else d_hold--;
            end
            i_valid = i_pres;
            i_addr  = i_pres ? iq[0] : 32'h0;
            d_valid = d_pres;
            d_write = d_pres ? dq[0].write : 1'b0;
            d_strobe = d_pres ? dq[0].strobe : 4'h0;
            d_addr  = d_pres ? dq[0].addr : 32'h0;
            d_wdata = d_pres ? dq[0].wdata : 32'h0;
            m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = $urandom;
            if (mem_dph) begin
                if (mem_lat == 0) begin
                    m_data_ok = 1'b1; m_rdata = mem_rd; mem_dph = 0;
                end else begin
                    mem_lat--;
                end
            end else if (m_valid && $urandom_range(99) < acc_pct) begin
                m_addr_ok = 1'b1;
                mem_rd = $urandom;
                if ($urandom_range(99) < same_pct) begin
                    m_data_ok = 1'b1; m_rdata = mem_rd;
                end else begin
                    mem_dph = 1; mem_lat = $urandom_range(lat_max);
                end
            end
            #1;
            check("trf_m_valid", m_valid, outst && addr_ph);
            if (outst && addr_ph) begin
                if (cur) begin
                    w = dq[0].write;
                    e_addr = dq[0].addr;
                    e_strb = w ? dq[0].strobe : 4'h0;
                    e_wdata = w ? dq[0].wdata : 32'h0;
                end else begin
                    w = 0; e_addr = iq[0]; e_strb = 4'h0; e_wdata = 32'h0;
                end
                check("trf_m_addr", m_addr, e_addr);
                check("trf_m_write", m_write, w);
                check("trf_m_strobe", m_strobe, e_strb);
                check("trf_m_wdata", m_wdata, e_wdata);
            end
            done  = outst && (addr_ph ? (m_addr_ok && m_data_ok) : m_data_ok);
            e_iok = done && !cur;
            e_dok = done && cur;
            check("trf_i_ok", i_ok, e_iok);
            check("trf_d_ok", d_ok, e_dok);
            check("trf_i_rdata", i_rdata, e_iok ? m_rdata : 32'h0);
            check("trf_d_rdata", d_rdata, e_dok ? m_rdata : 32'h0);
            if (i_ok) iok_cnt++;
            if (d_ok) dok_cnt++;
            if (outst) begin
                if (done) begin
                    outst = 0;
                    log_q.push_back(cur);
                    if (cur) begin
                        void'(dq.pop_front()); d_pres = 0; d_hold = $urandom_range(gap_max);
                    end else begin
                        void'(iq.pop_front()); i_pres = 0; i_hold = $urandom_range(gap_max);
                    end
                end else if (addr_ph && m_addr_ok) begin
                    addr_ph = 0;
                end
            end else if (i_valid || d_valid) begin
`ifdef MEM_ARB_RR_EN
                if (i_valid && d_valid) cur = !last_src;
                else cur = d_valid;
                last_src = cur;
`else
                cur = d_valid;
`endif
                outst = 1; addr_ph = 1;
            end
            cyc++;
        end
        check("trf_drained", (iq.size() == 0 && dq.size() == 0 && !outst), 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv;  logic [31:0] ia;
        logic        dv;  logic        dw; logic [3:0] ds; logic [31:0] da; logic [31:0] dwd;
        logic        aok; logic        dok; logic [31:0] rd;
        logic        e_mv; logic       e_mw; logic [3:0] e_ms; logic [31:0] e_ma; logic [31:0] e_mwd;
        logic        e_iok; logic      e_dok; logic [31:0] e_ird; logic [31:0] e_drd;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vt[NVEC];

    bit exp_order[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //        iv    ia             dv    dw    ds    da             dwd            aok   dok   rd             e_mv  e_mw  e_ms  e_ma           e_mwd          e_iok e_dok e_ird          e_drd
        vt[0]  = '{1'b1,32'hBFC0_0000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[1]  = '{1'b1,32'hBFC0_0000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b1,1'b0,32'h0,         1'b1,1'b0,4'h0,32'hBFC0_0000, 32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[2]  = '{1'b1,32'hBFC0_0000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b1,32'h2408_0001, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b1,1'b0,32'h2408_0001, 32'h0};
        vt[3]  = '{1'b0,32'h0,         1'b1,1'b1,4'h3,32'h8000_0010, 32'hDEAD_BEEF, 1'b0,1'b0,32'h1234_5678, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[4]  = '{1'b0,32'h0,         1'b1,1'b1,4'h3,32'h8000_0010, 32'hDEAD_BEEF, 1'b1,1'b1,32'h0,         1'b1,1'b1,4'h3,32'h8000_0010, 32'hDEAD_BEEF, 1'b0,1'b1,32'h0,         32'h0};
        vt[5]  = '{1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h7777_7777, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[6]  = '{1'b0,32'h0,         1'b1,1'b0,4'hF,32'h0000_0100, 32'h1357_9BDF, 1'b0,1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[7]  = '{1'b0,32'h0,         1'b1,1'b0,4'hF,32'h0000_0100, 32'h1357_9BDF, 1'b0,1'b0,32'h0,         1'b1,1'b0,4'h0,32'h0000_0100, 32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[8]  = '{1'b0,32'h0,         1'b1,1'b0,4'hF,32'h0000_0100, 32'h1357_9BDF, 1'b1,1'b0,32'h0,         1'b1,1'b0,4'h0,32'h0000_0100, 32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[9]  = '{1'b0,32'h0,         1'b1,1'b0,4'hF,32'h0000_0100, 32'h1357_9BDF, 1'b0,1'b0,32'h5555_5555, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[10] = '{1'b0,32'h0,         1'b1,1'b0,4'hF,32'h0000_0100, 32'h1357_9BDF, 1'b0,1'b1,32'hCAFE_F00D, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b1,32'h0,         32'hCAFE_F00D};
        vt[11] = '{1'b1,32'h0000_1000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[12] = '{1'b1,32'h0000_1000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         1'b1,1'b0,4'h0,32'h0000_1000, 32'h0,         1'b0,1'b0,32'h0,         32'h0};
        vt[13] = '{1'b1,32'h0000_1000, 1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b1,1'b1,32'h0BAD_CAFE, 1'b1,1'b0,4'h0,32'h0000_1000, 32'h0,         1'b1,1'b0,32'h0BAD_CAFE, 32'h0};
        vt[14] = '{1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         1'b0,1'b0,4'h0,32'h0,         32'h0,         1'b0,1'b0,32'h0,         32'h0};

        do_reset();

        for (int k = 0; k < NVEC; k++) begin
            @(posedge clk); #1;
            i_valid = vt[k].iv; i_addr = vt[k].ia;
            d_valid = vt[k].dv; d_write = vt[k].dw; d_strobe = vt[k].ds;
            d_addr = vt[k].da; d_wdata = vt[k].dwd;
            m_addr_ok = vt[k].aok; m_data_ok = vt[k].dok; m_rdata = vt[k].rd;
            #1;
            check($sformatf("vec%0d_m_valid", k), m_valid, vt[k].e_mv);
            if (vt[k].e_mv) begin
                check($sformatf("vec%0d_m_write", k), m_write, vt[k].e_mw);
                check($sformatf("vec%0d_m_strobe", k), m_strobe, vt[k].e_ms);
                check($sformatf("vec%0d_m_addr", k), m_addr, vt[k].e_ma);
                check($sformatf("vec%0d_m_wdata", k), m_wdata, vt[k].e_mwd);
            end
            check($sformatf("vec%0d_i_ok", k), i_ok, vt[k].e_iok);
            check($sformatf("vec%0d_d_ok", k), d_ok, vt[k].e_dok);
            check($sformatf("vec%0d_i_rdata", k), i_rdata, vt[k].e_ird);
            check($sformatf("vec%0d_d_rdata", k), d_rdata, vt[k].e_drd);
        end

        // Contention: both sides raise together and keep requesting.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            dreq_t r;
            iq.push_back(32'h0040_0000 + 32'(k * 4));
            r.write = 1'b0; r.strobe = 4'h0; r.addr = 32'h1000_0000 + 32'(k * 4); r.wdata = 32'h0;
            dq.push_back(r);
        end
        log_q.delete();
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        run_traffic(200, 0, 100, 0, 0);
        check("contend_count", log_q.size(), 6);
        for (int k = 0; k < 6 && k < log_q.size(); k++)
            check($sformatf("contend_order%0d", k), log_q[k], exp_order[k]);

        // Back-to-back loads: four held requests, four pulses.
        dok_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            dreq_t r;
            r.write = 1'b0; r.strobe = 4'hF; r.addr = 32'h2000_0000 + 32'(k * 4); r.wdata = 32'h0;
            dq.push_back(r);
        end
        run_traffic(200, 0, 100, 0, 0);
        check("b2b_d_ok_count", dok_cnt, 4);

        // Randomized mixed traffic.
        iok_cnt = 0; dok_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            dreq_t r;
            iq.push_back($urandom);
            r.write = 1'($urandom_range(1)); r.strobe = 4'($urandom);
            r.addr = $urandom; r.wdata = $urandom;
            dq.push_back(r);
        end
        run_traffic(3000, 3, 60, 30, 3);
        check("rand_i_ok_count", iok_cnt, 25);
        check("rand_d_ok_count", dok_cnt, 25);

        // Reset in the middle of a load's data phase.
        @(posedge clk); #1;
        drive_zero();
        d_valid = 1'b1; d_addr = 32'h0000_0040;
        #1; check("midrst_idle_m_valid", m_valid, 0);
        @(posedge clk); #1;
        m_addr_ok = 1'b1;
        #1; check("midrst_addr_m_valid", m_valid, 1);
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        #1; check("midrst_data_m_valid", m_valid, 0);
        check("midrst_data_d_ok", d_ok, 0);
        #2;
        resetn = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h0000_FFFF;
        #1;
        check("midrst_rst_m_valid", m_valid, 0);
        check("midrst_rst_d_ok", d_ok, 0);
        check("midrst_rst_d_rdata", d_rdata, 0);
        drive_zero();
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        #1; check("midrst_rel_m_valid", m_valid, 0);
        @(posedge clk); #1;
        d_valid = 1'b1; d_write = 1'b1; d_strobe = 4'hC; d_addr = 32'h0000_0080; d_wdata = 32'h89AB_CDEF;
        #1; check("midrst_idle2_m_valid", m_valid, 0);
        @(posedge clk); #1;
        m_addr_ok = 1'b1; m_data_ok = 1'b1;
        #1;
        check("midrst_post_m_valid", m_valid, 1);
        check("midrst_post_m_strobe", m_strobe, 4'hC);
        check("midrst_post_d_ok", d_ok, 1);
        @(posedge clk); #1;
        drive_zero();
        #1; check("midrst_final_m_valid", m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
